// File: rtl/sensor_frame_pkg.sv
// Shared types and constants for the 9-axis sensor frame collector.
package sensor_frame_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int AXIS_W      = 16;
    localparam int SENSOR_W    = 48;
    localparam int NUM_SENSORS = 3;

    localparam int ACC  = 0;
    localparam int GYRO = 1;
    localparam int MAG  = 2;

    // Swap the two bytes of every 16-bit axis inside a 48-bit sensor word.
    function automatic logic [SENSOR_W-1:0] swap_axes(input logic [SENSOR_W-1:0] word);
        logic [SENSOR_W-1:0] swapped;
        swapped = '0;
        for (int a = 0; a < SENSOR_W / AXIS_W; a++) begin
            swapped[a*AXIS_W +: AXIS_W] = {word[a*AXIS_W +: 8], word[a*AXIS_W + 8 +: 8]};
        end
        return swapped;
    endfunction

endpackage

// File: rtl/sensor_capture_lane.sv
// One sensor channel: read-pulse generation, holding register, captured flag
// and overrun strobe.
module sensor_capture_lane
    import sensor_frame_pkg::*;
#(
    parameter bit SWAP_BYTES = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  logic                clear,
    input  logic                ready,
    input  logic [SENSOR_W-1:0] data,
    output logic                read,
    output logic [SENSOR_W-1:0] word,
    output logic                captured,
    output logic                overrun
);

    logic read_prev;

    // Upstream needs one cycle to drop ready after a read, so never read twice in a row.
    assign read    = enable & ready & ~read_prev;
    assign overrun = read & captured;

    // Remember last cycle's read pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            read_prev <= 1'b0;
        end else begin
            read_prev <= read;
        end
    end

    // Capture the word on the read edge; a repeated read overwrites (newest wins).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word <= '0;
        end else if (read) begin
            word <= SWAP_BYTES ? swap_axes(data) : data;
        end
    end

    // Captured flag; a frame-level clear wins over a same-cycle read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            captured <= 1'b0;
        end else if (clear) begin
            captured <= 1'b0;
        end else if (read) begin
            captured <= 1'b1;
        end
    end

endmodule

// File: rtl/sensor_frame_collector.sv
// Assembles accelerometer, gyroscope and magnetometer words into one 9-axis
// frame, presents it on valid/ready and drops stale partial frames on timeout.
//
// state   | meaning
// COLLECT | lanes drain upstream words until all three are captured
// PRESENT | frame held stable on frame_data until frame_ready
module sensor_frame_collector
    import sensor_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter bit          SWAP_BYTES     = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  acc_ready,
    input  logic                  gyro_ready,
    input  logic                  mag_ready,
    input  logic [SENSOR_W-1:0]   acc_data,
    input  logic [SENSOR_W-1:0]   gyro_data,
    input  logic [SENSOR_W-1:0]   mag_data,
    output logic                  acc_read,
    output logic                  gyro_read,
    output logic                  mag_read,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [9*AXIS_W-1:0]   frame_data,
    output logic [15:0]           frame_seq,
    output logic                  frame_drop,
    output logic [7:0]            drop_count,
    output logic [7:0]            overrun_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t state, state_next;

    logic                collecting;
    logic [2:0]          ready_v, read_v, captured_v, overrun_v;
    logic [SENSOR_W-1:0] data_v [NUM_SENSORS];
    logic [SENSOR_W-1:0] word_v [NUM_SENSORS];
    logic                mask_full_next;
    logic                first_capture;
    logic                timer_hit;
    logic                drop;
    logic                accept;
    logic                lane_clear;
    logic [TW-1:0]       timer;
    logic [1:0]          overrun_n;
    logic [8:0]          overrun_sum;

    assign ready_v      = {mag_ready, gyro_ready, acc_ready};
    assign data_v[ACC]  = acc_data;
    assign data_v[GYRO] = gyro_data;
    assign data_v[MAG]  = mag_data;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_lane
        sensor_capture_lane #(
            .SWAP_BYTES(SWAP_BYTES)
        ) u_lane (
            .clk      (clk),
            .n_rst    (n_rst),
            .enable   (collecting),
            .clear    (lane_clear),
            .ready    (ready_v[i]),
            .data     (data_v[i]),
            .read     (read_v[i]),
            .word     (word_v[i]),
            .captured (captured_v[i]),
            .overrun  (overrun_v[i])
        );
    end

    assign acc_read   = read_v[ACC];
    assign gyro_read  = read_v[GYRO];
    assign mag_read   = read_v[MAG];
    assign frame_data = {word_v[ACC], word_v[GYRO], word_v[MAG]};

    // A capture landing on the timeout cycle still completes the frame.
    assign mask_full_next = &(captured_v | read_v);
    assign first_capture  = collecting & (captured_v == 3'b000) & (|read_v);
    assign timer_hit      = collecting & (|captured_v) & (timer == '0);
    assign drop           = timer_hit & ~mask_full_next;
    assign accept         = frame_valid & frame_ready;
    assign lane_clear     = accept | drop;
    assign frame_drop     = drop;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (mask_full_next) state_next = PRESENT;
            PRESENT: if (frame_ready)    state_next = COLLECT;
            default:                     state_next = COLLECT;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        collecting  = 1'b0;
        frame_valid = 1'b0;
        case (state)
            COLLECT: collecting  = 1'b1;
            PRESENT: frame_valid = 1'b1;
            default: collecting  = 1'b1;
        endcase
    end

    // Frame age down-counter, loaded at the first capture of a frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer <= '0;
        end else if (first_capture) begin
            timer <= TIMER_LOAD;
        end else if (collecting && (|captured_v) && (timer != '0)) begin
            timer <= timer - TW'(1);
        end
    end

    // Sequence number of the presented frame, advanced on each accept.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frame_seq <= '0;
        end else if (accept) begin
            frame_seq <= frame_seq + 16'd1;
        end
    end

    // Saturating count of dropped partial frames.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Several lanes may overrun in the same cycle; each one counts.
    assign overrun_n   = 2'(overrun_v[0]) + 2'(overrun_v[1]) + 2'(overrun_v[2]);
    assign overrun_sum = {1'b0, overrun_count} + {7'b0, overrun_n};

    // Saturating count of overwritten lane captures.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun_count <= '0;
        end else if (overrun_sum[8]) begin
            overrun_count <= 8'hFF;
        end else begin
            overrun_count <= overrun_sum[7:0];
        end
    end

endmodule

// File: tb/tb_sensor_frame_collector.sv
// Directed bench for sensor_frame_collector with a per-cycle reference model
// and an upstream model that keeps ready high one cycle after each read.
module tb_sensor_frame_collector;

    localparam int T = 100;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         acc_ready = 1'b0, gyro_ready = 1'b0, mag_ready = 1'b0;
    logic [47:0]  acc_data = '0, gyro_data = '0, mag_data = '0;
    logic         acc_read, gyro_read, mag_read;
    logic         frame_valid;
    logic         frame_ready = 1'b0;
    logic [143:0] frame_data;
    logic [15:0]  frame_seq;
    logic         frame_drop;
    logic [7:0]   drop_count, overrun_count;

    sensor_frame_collector #(
        .TIMEOUT_CYCLES(T),
        .SWAP_BYTES    (1'b1)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .acc_ready    (acc_ready),
        .gyro_ready   (gyro_ready),
        .mag_ready    (mag_ready),
        .acc_data     (acc_data),
        .gyro_data    (gyro_data),
        .mag_data     (mag_data),
        .acc_read     (acc_read),
        .gyro_read    (gyro_read),
        .mag_read     (mag_read),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .frame_seq    (frame_seq),
        .frame_drop   (frame_drop),
        .drop_count   (drop_count),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // upstream word queues, index 0=acc 1=gyro 2=mag
    logic [47:0] upq [3][$];
    bit          pop_pend [3];

    // reference model
    bit          m_collect;
    bit          m_cap [3];
    logic [47:0] m_data [3];
    bit          m_rdprev [3];
    int          m_seq, m_drops, m_ovr, m_first;

    // last sampled observations
    logic [2:0]  s_rd;
    bit          s_valid, s_drop;
    int          last_acc_rd, read_pulses;

    function automatic logic [47:0] bench_swap(input logic [47:0] w);
        return {w[39:32], w[47:40], w[23:16], w[31:24], w[7:0], w[15:8]};
    endfunction

    task automatic check(input string nm, input logic [143:0] act, input logic [143:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_collect = 1'b1;
        m_seq = 0; m_drops = 0; m_ovr = 0; m_first = 0;
        for (int i = 0; i < 3; i++) begin
            m_cap[i] = 1'b0; m_data[i] = '0; m_rdprev[i] = 1'b0;
            pop_pend[i] = 1'b0;
            upq[i].delete();
        end
    endtask

    // One clock cycle: drive upstream, compare at negedge, advance the model.
    task automatic tick();
        logic        rdy [3];
        logic [47:0] dat [3];
        logic [2:0]  er;
        bit          was_collect, any_cap, fulln, ed;
        logic [143:0] ef;
        for (int i = 0; i < 3; i++) begin
            rdy[i] = (upq[i].size() > 0);
            dat[i] = rdy[i] ? upq[i][0] : 48'h0;
        end
        acc_ready = rdy[0]; gyro_ready = rdy[1]; mag_ready = rdy[2];
        acc_data  = dat[0]; gyro_data  = dat[1]; mag_data  = dat[2];
        @(negedge clk);
        was_collect = m_collect;
        any_cap = m_cap[0] | m_cap[1] | m_cap[2];
        for (int i = 0; i < 3; i++) er[i] = was_collect && rdy[i] && !m_rdprev[i];
        fulln = (m_cap[0] | er[0]) && (m_cap[1] | er[1]) && (m_cap[2] | er[2]);
        ed = was_collect && any_cap && (cyc == m_first + T) && !fulln;
        ef = {bench_swap(m_data[0]), bench_swap(m_data[1]), bench_swap(m_data[2])};

        s_rd = {mag_read, gyro_read, acc_read};
        s_valid = frame_valid;
        s_drop = frame_drop;
        if (acc_read) last_acc_rd = cyc;
        read_pulses += int'(acc_read) + int'(gyro_read) + int'(mag_read);

        check("reads", 144'(s_rd), 144'(er));
        check("frame_valid", 144'(frame_valid), 144'(!was_collect));
        check("frame_drop", 144'(frame_drop), 144'(ed));
        check("frame_seq", 144'(frame_seq), 144'(m_seq[15:0]));
        check("drop_count", 144'(drop_count), 144'(m_drops));
        check("overrun_count", 144'(overrun_count), 144'(m_ovr));
        if (!was_collect) check("frame_data", frame_data, ef);

        for (int i = 0; i < 3; i++) begin
            if (er[i]) begin
                if (m_cap[i] && m_ovr < 255) m_ovr++;
                m_data[i] = dat[i];
                m_cap[i] = 1'b1;
            end
        end
        if (was_collect && !any_cap && er != 3'b000) m_first = cyc;
        if (was_collect) begin
            if (fulln) m_collect = 1'b0;
            else if (ed) begin
                for (int i = 0; i < 3; i++) m_cap[i] = 1'b0;
                if (m_drops < 255) m_drops++;
            end
        end else if (frame_ready) begin
            m_collect = 1'b1;
            for (int i = 0; i < 3; i++) m_cap[i] = 1'b0;
            m_seq = (m_seq + 1) & 16'hFFFF;
        end
        for (int i = 0; i < 3; i++) m_rdprev[i] = er[i];

        for (int i = 0; i < 3; i++) begin
            if (pop_pend[i]) begin
                if (upq[i].size() > 0) void'(upq[i].pop_front());
                pop_pend[i] = 1'b0;
            end
            if (s_rd[i]) pop_pend[i] = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_valid(input int budget, input string nm, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (s_valid) begin
                at = cyc - 1;
                break;
            end
        end
        if (at < 0) begin
            tests++; fails++;
            $display("FAIL %s timeout got=no_valid expected=valid", nm);
        end
    endtask

    int c0, at, a, drop_cyc;

    initial begin
        read_pulses = 0;
        last_acc_rd = -1;
        model_reset();
        #1;
        check("reset frame_data", frame_data, 144'h0);
        check("reset frame_valid", 144'(frame_valid), 144'h0);
        check("reset reads", 144'({mag_read, gyro_read, acc_read}), 144'h0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        run(2);

        // all three ready together
        upq[0].push_back(48'h0102_0304_0506);
        upq[1].push_back(48'hA1A2_B1B2_C1C2);
        upq[2].push_back(48'h1357_2468_9ABC);
        c0 = cyc;
        wait_valid(5, "s1_valid", at);
        check("s1 valid latency", 144'(at - c0), 144'd1);
        check("s1 acc_x", 144'(frame_data[143:128]), 144'h0201);
        check("s1 acc_z", 144'(frame_data[111:96]), 144'h0605);
        check("s1 frame_seq", 144'(frame_seq), 144'h0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        run(2);

        // staggered readies with frame_ready held high
        frame_ready = 1'b1;
        c0 = cyc;
        upq[0].push_back(48'h1111_2222_3333);
        run(10);
        upq[1].push_back(48'h4444_5555_6666);
        run(10);
        upq[2].push_back(48'h7777_8888_9999);
        tick();
        upq[0].push_back(48'h0A0B_0C0D_0E0F);
        tick();
        check("s2 valid cycle", 144'(s_valid ? cyc - 1 - c0 : -1), 144'd21);
        tick();
        check("s2 read resume", 144'(last_acc_rd - c0), 144'd22);
        check("s2 frame_seq", 144'(frame_seq), 144'd2);

        // downstream stalls while all readies stay high
        frame_ready = 1'b0;
        upq[1].push_back(48'h0001_0002_0003);
        upq[2].push_back(48'h0004_0005_0006);
        upq[0].push_back(48'hC0C1_C2C3_C4C5);
        upq[1].push_back(48'hD0D1_D2D3_D4D5);
        upq[2].push_back(48'hE0E1_E2E3_E4E5);
        wait_valid(5, "s3_valid", at);
        read_pulses = 0;
        run(50);
        check("s3 no reads while held", 144'(read_pulses), 144'd0);
        check("s3 acc word held", 144'(frame_data[143:96]), 144'h0B0A_0D0C_0F0E);
        frame_ready = 1'b1;
        run(10);

        // timeout with only acc delivered
        upq[0].push_back(48'h1234_5678_9ABC);
        tick();
        a = last_acc_rd;
        drop_cyc = -1;
        for (int k = 0; k < T + 20; k++) begin
            tick();
            if (s_drop) begin
                drop_cyc = cyc - 1;
                break;
            end
        end
        check("s4 drop distance", 144'(drop_cyc - a), 144'(T));
        run(1);
        check("s4 drop_count", 144'(drop_count), 144'd1);

        // last lane captured exactly on the timeout cycle completes the frame
        upq[0].push_back(48'h2222_3333_4444);
        a = cyc;
        tick();
        run(4);
        upq[1].push_back(48'h5555_6666_7777);
        while (cyc < a + T) tick();
        upq[2].push_back(48'h8888_9999_AAAA);
        tick();
        check("s4b no drop on completion", 144'(s_drop), 144'd0);
        check("s4b mag read on timeout cycle", 144'(s_rd[2]), 144'd1);
        tick();
        check("s4b frame_valid", 144'(s_valid), 144'd1);
        check("s4b drop_count", 144'(drop_count), 144'd1);
        run(3);

        // acc delivered twice before the frame completes
        frame_ready = 1'b0;
        upq[0].push_back(48'h1111_2222_3333);
        upq[0].push_back(48'hFFFF_0000_1234);
        run(5);
        upq[1].push_back(48'h0101_0202_0303);
        upq[2].push_back(48'h0404_0505_0606);
        wait_valid(6, "s5_valid", at);
        check("s5 overrun_count", 144'(overrun_count), 144'd1);
        check("s5 acc newest word", 144'(frame_data[143:96]), 144'hFFFF_0000_3412);
        run(2);

        // asynchronous reset while presenting
        n_rst = 1'b0;
        #1;
        check("rst frame_valid", 144'(frame_valid), 144'h0);
        check("rst frame_seq", 144'(frame_seq), 144'h0);
        check("rst frame_data", frame_data, 144'h0);
        check("rst counters", 144'({drop_count, overrun_count}), 144'h0);
        @(posedge clk);
        #1;
        model_reset();
        n_rst = 1'b1;
        upq[0].push_back(48'hAAAA_BBBB_CCCC);
        upq[1].push_back(48'hDDDD_EEEE_FFFF);
        upq[2].push_back(48'h0F0F_F0F0_55AA);
        tick();
        check("post-reset first reads", 144'(s_rd), 144'h7);
        frame_ready = 1'b1;
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
